// File: rtl/out_generator_pkg.sv
// Shared types and constants for the marker/bit/strobe frame generator.
package out_generator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    SETUP,
    STROBE,
    GAP
  } og_state_t;

  localparam int OG_MK_LEN   = 4;
  localparam int OG_HALF_LEN = 4;
  localparam int OG_GAP_LEN  = 12;

  localparam int OG_MIN_MK   = 3;
  localparam int OG_MIN_HALF = 3;
  localparam int OG_MIN_GAP  = 10;

  function automatic int og_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/og_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module og_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [W-1:0] val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/out_generator.sv
// Byte-to-serial frame generator: marker, then 8 bits MSB-first with strobes.
// Define OUT_GENERATOR_HOLD_EN to add a one-byte holding register.
module out_generator
  import out_generator_pkg::*;
#(
  parameter int MK_LEN   = OG_MK_LEN,
  parameter int HALF_LEN = OG_HALF_LEN,
  parameter int GAP_LEN  = OG_GAP_LEN
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] dataIn,
  output logic       ready,
  output logic       busy,
  output logic       ovf,
  output logic       dMK,
  output logic       outBit,
  output logic       outVal
);

  localparam int CW =
    $clog2(og_max3(MK_LEN, HALF_LEN, GAP_LEN) + 1);
  localparam logic [CW-1:0] MK_LD   = CW'(MK_LEN - 1);
  localparam logic [CW-1:0] HALF_LD = CW'(HALF_LEN - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_LEN - 1);

  if (MK_LEN < OG_MIN_MK || HALF_LEN < OG_MIN_HALF ||
      GAP_LEN < OG_MIN_GAP) begin : g_bad_param
    $error("out_generator: illegal timing parameter");
  end

  og_state_t     state;
  logic [2:0]    ptr;
  logic [7:0]    shreg;
  logic          t_ld;
  logic          t_done;
  logic [CW-1:0] t_val;
  logic          start_nxt;
  logic [7:0]    next_byte;

`ifdef OUT_GENERATOR_HOLD_EN
  logic       hold_full;
  logic [7:0] hold;

  assign ready     = (state == IDLE) || !hold_full;
  assign start_nxt = hold_full || load;
  assign next_byte = hold_full ? hold : dataIn;
`else
  assign ready     = (state == IDLE);
  assign start_nxt = 1'b0;
  assign next_byte = dataIn;
`endif

  og_phase_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .ld    (t_ld),
    .val   (t_val),
    .done  (t_done)
  );

  always_comb begin
    t_ld  = 1'b0;
    t_val = MK_LD;
    unique case (state)
      IDLE: t_ld = load;
      MARK, SETUP: begin
        t_ld  = t_done;
        t_val = HALF_LD;
      end
      STROBE: begin
        t_ld  = t_done;
        t_val = (ptr != 3'd0) ? HALF_LD : GAP_LD;
      end
      GAP: t_ld = t_done && start_nxt;
      default: t_ld = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= 3'd7;
      shreg  <= '0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
      dMK    <= 1'b0;
      outBit <= 1'b0;
      outVal <= 1'b0;
`ifdef OUT_GENERATOR_HOLD_EN
      hold      <= '0;
      hold_full <= 1'b0;
`endif
    end else begin
      ovf <= load && !ready;
      unique case (state)
        IDLE: if (load) begin
          shreg <= dataIn;
          ptr   <= 3'd7;
          state <= MARK;
          dMK   <= 1'b1;
          busy  <= 1'b1;
        end
        MARK: if (t_done) begin
          state  <= SETUP;
          dMK    <= 1'b0;
          outBit <= shreg[ptr];
        end
        SETUP: if (t_done) begin
          state  <= STROBE;
          outVal <= 1'b1;
        end
        STROBE: if (t_done) begin
          outVal <= 1'b0;
          if (ptr != 3'd0) begin
            ptr    <= ptr - 3'd1;
            outBit <= shreg[ptr - 3'd1];
            state  <= SETUP;
          end else begin
            outBit <= 1'b0;
            state  <= GAP;
          end
        end
        GAP: if (t_done) begin
          // Back-to-back frame: skip IDLE entirely
          if (start_nxt) begin
            shreg <= next_byte;
            ptr   <= 3'd7;
            state <= MARK;
            dMK   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef OUT_GENERATOR_HOLD_EN
      if (state == GAP && t_done) begin
        hold_full <= 1'b0;
      end else if (load && ready && state != IDLE) begin
        hold      <= dataIn;
        hold_full <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_out_generator.sv
// Bench for out_generator: default and minimum-timing instances vs a frame-time model.
module tb_out_generator;

`ifdef OUT_GENERATOR_HOLD_EN
  localparam bit H = 1'b1;
`else
  localparam bit H = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] dataIn;
  logic [1:0] dmk, obit, oval, busy, ovf, rdy;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  out_generator dut0 (
    .clk(clk), .reset(reset), .load(load), .dataIn(dataIn),
    .ready(rdy[0]), .busy(busy[0]), .ovf(ovf[0]),
    .dMK(dmk[0]), .outBit(obit[0]), .outVal(oval[0])
  );

  out_generator #(.MK_LEN(3), .HALF_LEN(3), .GAP_LEN(10)) dut1 (
    .clk(clk), .reset(reset), .load(load), .dataIn(dataIn),
    .ready(rdy[1]), .busy(busy[1]), .ovf(ovf[1]),
    .dMK(dmk[1]), .outBit(obit[1]), .outVal(oval[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Frame-time model: a frame is a timeline of t = 0..len-1 cycles
  function automatic int mk(input int i);   return i == 0 ? 4 : 3;  endfunction
  function automatic int hl(input int i);   return i == 0 ? 4 : 3;  endfunction
  function automatic int gp(input int i);   return i == 0 ? 12 : 10; endfunction
  function automatic int flen(input int i);
    return mk(i) + 16 * hl(i) + gp(i);
  endfunction

  typedef struct {
    bit         act;
    int         t;
    logic [7:0] b;
    bit         pv;
    logic [7:0] pb;
    bit         ovf;
  } mdl_t;
  mdl_t m [2];

  function automatic void m_reset(input int i);
    m[i].act = 0; m[i].t = 0; m[i].b = '0;
    m[i].pv = 0; m[i].pb = '0; m[i].ovf = 0;
  endfunction

  function automatic bit m_rdy(input int i);
    return !m[i].act || (H && !m[i].pv);
  endfunction

  function automatic logic [5:0] m_out(input int i);
    int   ph;
    logic d_e, b_e, v_e;
    d_e = 0; b_e = 0; v_e = 0;
    if (m[i].act) begin
      if (m[i].t < mk(i)) begin
        d_e = 1;
      end else if (m[i].t < mk(i) + 16 * hl(i)) begin
        ph  = (m[i].t - mk(i)) / hl(i);
        b_e = m[i].b[7 - ph / 2];
        v_e = (ph % 2) == 1;
      end
    end
    return {d_e, b_e, v_e, m[i].act, m[i].ovf, m_rdy(i)};
  endfunction

  function automatic void m_step(input int i, input bit ld,
                                 input logic [7:0] d);
    bit r;
    bit go;
    r  = m_rdy(i);
    go = 0;
    m[i].ovf = ld && !r;
    if (ld && r) begin
      if (!m[i].act) go = 1;
      else begin m[i].pv = 1; m[i].pb = d; end
    end
    if (m[i].act) begin
      m[i].t++;
      if (m[i].t == flen(i)) begin
        if (m[i].pv) begin
          m[i].t = 0; m[i].b = m[i].pb; m[i].pv = 0;
        end else begin
          m[i].act = 0;
        end
      end
    end
    if (go) begin m[i].act = 1; m[i].t = 0; m[i].b = d; end
  endfunction

  // Loopback receiver: sample the bit on each strobe front
  logic [7:0] rx_sh [2];
  int         rx_n  [2];
  logic [1:0] p_dmk = '0;
  logic [1:0] p_val = '0;
  logic [7:0] rx0 [$];
  logic [7:0] rx1 [$];

  task automatic rx_tick();
    for (int i = 0; i < 2; i++) begin
      if (dmk[i] && !p_dmk[i]) rx_n[i] = 0;
      if (oval[i] && !p_val[i]) begin
        rx_sh[i] = {rx_sh[i][6:0], obit[i]};
        rx_n[i]++;
        if (rx_n[i] == 8) begin
          if (i == 0) rx0.push_back(rx_sh[i]);
          else rx1.push_back(rx_sh[i]);
        end
      end
    end
    p_dmk = dmk;
    p_val = oval;
  endtask

  task automatic step(input bit ld, input logic [7:0] d,
                      input bit wr, output bit took);
    bit l;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("model%0d@%0d", i, cyc),
          {2'b0, dmk[i], obit[i], oval[i], busy[i], ovf[i], rdy[i]},
          {2'b0, m_out(i)});
    rx_tick();
    l = ld && (!wr || rdy == 2'b11);
    load = l;
    dataIn = d;
    for (int i = 0; i < 2; i++) m_step(i, l, d);
    took = l;
  endtask

  task automatic send(input logic [7:0] d);
    bit tk;
    tk = 0;
    for (int k = 0; k < 400 && !tk; k++) step(1'b1, d, 1'b1, tk);
    if (!tk) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got ready=%b want 11", rdy);
    end
  endtask

  task automatic wait_idle();
    bit tk;
    bit ok;
    ok = 0;
    for (int k = 0; k < 600 && !ok; k++) begin
      step(1'b0, 8'h00, 1'b0, tk);
      ok = (busy == 2'b00);
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got busy=%b want 00", busy);
    end
  endtask

  typedef struct {
    int         c;
    logic [5:0] e;
  } tv_t;
  tv_t tbl [$];

  function automatic void add(input int c, input logic [5:0] e);
    tv_t v;
    v.c = c;
    v.e = e;
    tbl.push_back(v);
  endfunction

  initial begin
    bit         tk;
    logic [7:0] exp3 [3];
    exp3 = '{8'h00, 8'hFF, 8'h3C};

    // {dMK, outBit, outVal, busy, ovf, ready} for 8'hA5, second load at 20
    add(0,  6'b000001);
    add(1,  {4'b1001, 1'b0, H});
    add(4,  {4'b1001, 1'b0, H});
    add(5,  {4'b0101, 1'b0, H});
    add(8,  {4'b0101, 1'b0, H});
    add(9,  {4'b0111, 1'b0, H});
    add(12, {4'b0111, 1'b0, H});
    add(13, {4'b0001, 1'b0, H});
    add(17, {4'b0011, 1'b0, H});
    add(21, {4'b0101, !H, 1'b0});
    add(25, 6'b011100);
    add(33, 6'b001100);
    add(41, 6'b001100);
    add(49, 6'b011100);
    add(57, 6'b001100);
    add(65, 6'b011100);
    add(68, 6'b011100);
    add(69, 6'b000100);
    add(80, 6'b000100);
    add(81, {H, 2'b00, H, 1'b0, 1'b1});

    reset = 1'b1;
    load = 1'b0;
    dataIn = 8'h00;
    for (int i = 0; i < 2; i++) m_reset(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset%0d", i),
          {2'b0, dmk[i], obit[i], oval[i], busy[i], ovf[i], rdy[i]},
          8'h01);
    reset = 1'b0;

    for (int k = 0; k <= 82; k++) begin
      step(k == 0 || k == 20, (k == 20) ? 8'h5A : 8'hA5, 1'b0, tk);
      foreach (tbl[j])
        if (tbl[j].c == k)
          chk($sformatf("a5_c%0d", k),
              {2'b0, dmk[0], obit[0], oval[0], busy[0], ovf[0], rdy[0]},
              {2'b0, tbl[j].e});
    end
    wait_idle();

    step(1'b1, 8'h11, 1'b0, tk);
    step(1'b1, 8'h22, 1'b0, tk);
    step(1'b1, 8'h33, 1'b0, tk);
    wait_idle();

    rx0.delete();
    rx1.delete();
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    wait_idle();
    chk("rx0_count", 8'(rx0.size()), 8'd3);
    chk("rx1_count", 8'(rx1.size()), 8'd3);
    for (int j = 0; j < 3; j++) begin
      if (j < rx0.size()) chk($sformatf("rx0_%0d", j), rx0[j], exp3[j]);
      if (j < rx1.size()) chk($sformatf("rx1_%0d", j), rx1[j], exp3[j]);
    end

    // Abort mid-frame during the strobe of bit 3
    send(8'hC3);
    for (int k = 1; k <= 42; k++) step(1'b0, 8'h00, 1'b0, tk);
    chk("strobe_b3", {7'b0, oval[0]}, 8'h01);
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("abort%0d", i),
          {2'b0, dmk[i], obit[i], oval[i], busy[i], ovf[i], rdy[i]},
          8'h01);
    for (int i = 0; i < 2; i++) m_reset(i);
    @(negedge clk);
    reset = 1'b0;
    rx0.delete();
    rx1.delete();
    send(8'h96);
    wait_idle();
    chk("rx0_after_abort", (rx0.size() == 1) ? rx0[0] : 8'hxx, 8'h96);
    chk("rx1_after_abort", (rx1.size() == 1) ? rx1[0] : 8'hxx, 8'h96);

    for (int k = 0; k < 4000; k++)
      step($urandom_range(0, 29) == 0, 8'($urandom), 1'b0, tk);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
